// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: parameter defaults and the
// packer state encoding that the SPI-side status logic also decodes.
package spi_pkg;
  localparam int BPW_DEFAULT     = 4;
  localparam int TIMEOUT_DEFAULT = 50000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } rx_state_e;
endpackage

// File: rtl/rx_idle_timer.sv
// Clearable idle counter that saturates at TIMEOUT_CYCLES-1 and flags the hit
// there, so a flush that cannot be taken yet stays pending.
module rx_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TO_W           = 16
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [TO_W-1:0] cnt;

  assign hit = (cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (Rst)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !hit) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_rx_packer.sv
// Packs SPI receive bytes MSB-first into words, flushes partial words on idle
// timeout and counts bytes dropped while a full word waits for the consumer.
module spi_rx_packer
  import spi_pkg::*;
#(
  parameter int BYTES_PER_WORD = BPW_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int TO_W           = 16
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic [7:0]                  rcv_data,
  input  logic                        recv_done,
  output logic [8*BYTES_PER_WORD-1:0] word_data,
  output logic [3:0]                  word_bytes,
  output logic                        word_valid,
  input  logic                        word_ready,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);
  localparam int W = 8 * BYTES_PER_WORD;
  localparam logic [3:0] BPW = 4'(BYTES_PER_WORD);

  rx_state_e  state;
  logic [W-1:0] asm_q, asm_d, ld_data, byte_at, byte_top;
  logic [3:0] cnt_q, cnt_d, ld_bytes;
  logic       free, load, drop, hit, tmr_clr, tmr_en;
  int         sh;

  assign free     = !word_valid || word_ready;
  assign byte_top = {rcv_data, {(W-8){1'b0}}};

  always_comb begin
    sh = 0;
    if (cnt_q < BPW) sh = 8 * (BYTES_PER_WORD - 1 - int'(cnt_q));
    byte_at = W'(rcv_data) << sh;
  end

  always_comb begin
    if (cnt_q == 4'd0)     state = ST_EMPTY;
    else if (cnt_q == BPW) state = ST_FULL;
    else                   state = ST_FILL;
  end

  // A pending timeout (hit but output busy) keeps the counter parked at hit.
  assign tmr_en  = (state == ST_FILL);
  assign tmr_clr = (state != ST_FILL) || (recv_done && !hit) || (hit && free);

  rx_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timer (
    .Clk (Clk),
    .Rst (Rst),
    .clr (tmr_clr),
    .en  (tmr_en),
    .hit (hit)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      asm_q <= '0;
      cnt_q <= '0;
    end else begin
      asm_q <= asm_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    asm_d    = asm_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    ld_data  = asm_q;
    ld_bytes = cnt_q;
    drop     = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (recv_done) begin
          asm_d = byte_top;
          cnt_d = 4'd1;
        end
      end
      ST_FILL: begin
        if (hit && free) begin
          // Flush the partial first; a same-cycle byte opens a fresh word.
          load  = 1'b1;
          asm_d = recv_done ? byte_top : '0;
          cnt_d = recv_done ? 4'd1 : 4'd0;
        end else if (recv_done) begin
          if (cnt_q == BPW - 4'd1 && free) begin
            load     = 1'b1;
            ld_data  = asm_q | byte_at;
            ld_bytes = BPW;
            asm_d    = '0;
            cnt_d    = 4'd0;
          end else begin
            asm_d = asm_q | byte_at;
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ST_FULL: begin
        if (free) begin
          load     = 1'b1;
          ld_bytes = BPW;
          asm_d    = recv_done ? byte_top : '0;
          cnt_d    = recv_done ? 4'd1 : 4'd0;
        end else if (recv_done) begin
          drop = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      word_valid <= 1'b0;
      word_data  <= '0;
      word_bytes <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word_data  <= ld_data;
      word_bytes <= ld_bytes;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_spi_rx_packer.sv
// Directed bench for spi_rx_packer: table of per-cycle vectors plus
// hand-written timeout, same-cycle flush and saturation sequences.
module tb_spi_rx_packer;
  localparam int BPW = 4;
  localparam int TO  = 16;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [7:0]  rcv_data;
  logic        recv_done;
  logic [31:0] word_data;
  logic [3:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  spi_rx_packer #(.BYTES_PER_WORD(BPW), .TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .rcv_data   (rcv_data),
    .recv_done  (recv_done),
    .word_data  (word_data),
    .word_bytes (word_bytes),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt)
  );

  always #10 Clk = ~Clk;

  typedef struct {
    logic        rst;
    logic        rd;
    logic [7:0]  d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  eb;
    logic        eo;
    logic [7:0]  edc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rd, input logic [7:0] d,
                     input logic rdy, input logic ev, input logic [31:0] ed,
                     input logic [3:0] eb, input logic eo, input logic [7:0] edc);
    vec_t v;
    v.rst = rst; v.rd = rd; v.d = d; v.rdy = rdy; v.ev = ev;
    v.ed = ed; v.eb = eb; v.eo = eo; v.edc = edc;
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rcv_data  = b;
    recv_done = 1'b1;
    cyc();
    recv_done = 1'b0;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    cyc();
    Rst = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; recv_done = 1'b0; rcv_data = 8'h00; word_ready = 1'b1;
    cyc(); cyc();
    chk("reset valid", word_valid, 1'b0);
    chk("reset data", word_data, 32'h0);
    chk("reset bytes", word_bytes, 4'd0);
    chk("reset ovf", overflow, 1'b0);
    chk("reset drop", drop_cnt, 8'd0);
    Rst = 1'b0;

    // Spaced bytes, ready high: one-cycle valid right after the 4th strobe.
    add(1, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    add(0, 1, 8'hA1, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    add(0, 1, 8'hB2, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    add(0, 1, 8'hC3, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 0; i < 3; i++) add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    add(0, 1, 8'hD4, 1, 1, 32'hA1B2C3D4, 4'd4, 0, 8'd0);
    add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    // Ready low: held word, second word in FULL, ninth byte dropped.
    add(1, 0, 8'h00, 0, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 1; i <= 3; i++) add(0, 1, 8'(i), 0, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 4; i <= 8; i++) add(0, 1, 8'(i), 0, 1, 32'h01020304, 4'd4, 0, 8'd0);
    add(0, 1, 8'h09, 0, 1, 32'h01020304, 4'd4, 1, 8'd1);
    add(0, 0, 8'h00, 1, 1, 32'h05060708, 4'd4, 1, 8'd1);
    add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 1, 8'd1);
    // Reset mid-word discards the partial and clears the sticky flags.
    add(0, 1, 8'hAA, 1, 0, 32'h0, 4'd0, 1, 8'd1);
    add(0, 1, 8'hBB, 1, 0, 32'h0, 4'd0, 1, 8'd1);
    add(0, 1, 8'hCC, 1, 0, 32'h0, 4'd0, 1, 8'd1);
    add(1, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);
    for (int i = 1; i <= 3; i++) add(0, 1, 8'(i), 1, 0, 32'h0, 4'd0, 0, 8'd0);
    add(0, 1, 8'h04, 1, 1, 32'h01020304, 4'd4, 0, 8'd0);
    add(0, 0, 8'h00, 1, 0, 32'h0, 4'd0, 0, 8'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      Rst = tbl[i].rst; recv_done = tbl[i].rd; rcv_data = tbl[i].d;
      word_ready = tbl[i].rdy;
      cyc();
      chk($sformatf("vec%0d valid", i), word_valid, tbl[i].ev);
      chk($sformatf("vec%0d ovf", i), overflow, tbl[i].eo);
      chk($sformatf("vec%0d drop", i), drop_cnt, tbl[i].edc);
      if (tbl[i].ev || tbl[i].rst) begin
        chk($sformatf("vec%0d data", i), word_data, tbl[i].ed);
        chk($sformatf("vec%0d bytes", i), word_bytes, tbl[i].eb);
      end
    end
    Rst = 1'b0; recv_done = 1'b0; word_ready = 1'b1;

    // Timeout flush of a 2-byte partial, TO cycles after the accepting edge.
    do_reset();
    send(8'h11);
    send(8'h22);
    for (int k = 1; k <= TO; k++) begin
      cyc();
      chk($sformatf("to valid k%0d", k), word_valid, (k == TO));
    end
    chk("to data", word_data, 32'h11220000);
    chk("to bytes", word_bytes, 4'd2);
    cyc();
    chk("to drain", word_valid, 1'b0);

    // Timeout hit and strobe in the same cycle with the output free.
    do_reset();
    send(8'h11);
    repeat (TO - 1) cyc();
    chk("tohit pre valid", word_valid, 1'b0);
    send(8'h5A);
    chk("tohit valid", word_valid, 1'b1);
    chk("tohit data", word_data, 32'h11000000);
    chk("tohit bytes", word_bytes, 4'd1);
    send(8'h6B);
    chk("tohit b2 valid", word_valid, 1'b0);
    send(8'h7C);
    send(8'h8D);
    chk("tohit next valid", word_valid, 1'b1);
    chk("tohit next data", word_data, 32'h5A6B7C8D);
    chk("tohit next bytes", word_bytes, 4'd4);

    // Sustained overrun: drop counter saturates, overflow stays set.
    do_reset();
    word_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send(8'(i));
      if (i == 8) chk("sat drop first", drop_cnt, 8'd1);
    end
    chk("sat drop", drop_cnt, 8'd255);
    chk("sat ovf", overflow, 1'b1);
    chk("sat held data", word_data, 32'h00010203);
    word_ready = 1'b1;
    cyc();
    chk("sat full valid", word_valid, 1'b1);
    chk("sat full data", word_data, 32'h04050607);
    cyc();
    chk("sat drain", word_valid, 1'b0);
    chk("sat drop hold", drop_cnt, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
